// File: rtl/ysyx_24100006_icache_if.sv
// Bundles the IFU-side and memory-side AXI read channels seen by the instruction cache.
// A transfer completes on a rising edge where valid && ready. A source holds valid and its payload until that edge; ready may change freely.
interface ysyx_24100006_icache_if;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rlast;
  logic        ifu_rready;
  logic [31:0] mem_araddr;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [7:0]  mem_arlen;
  logic [2:0]  mem_arsize;
  logic [1:0]  mem_arburst;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rvalid;
  logic        mem_rlast;
  logic        mem_rready;

  // slave is the cache itself; master is everything around it (IFU plus system bus)
  modport slave (
    input  ifu_araddr, ifu_arvalid, ifu_rready,
           mem_arready, mem_rdata, mem_rresp, mem_rvalid, mem_rlast,
    output ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid, ifu_rlast,
           mem_araddr, mem_arvalid, mem_arlen, mem_arsize, mem_arburst, mem_rready
  );

  modport master (
    output ifu_araddr, ifu_arvalid, ifu_rready,
           mem_arready, mem_rdata, mem_rresp, mem_rvalid, mem_rlast,
    input  ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid, ifu_rlast,
           mem_araddr, mem_arvalid, mem_arlen, mem_arsize, mem_arburst, mem_rready
  );
endinterface

// File: rtl/ysyx_24100006_icache.sv
// Direct-mapped read-only instruction cache: single-beat hits to the IFU,
// whole-line INCR refills on a miss, fence.i invalidation, hit/miss counters.
module ysyx_24100006_icache #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ysyx_24100006_icache_if.slave bus,
  input  logic                  fence_i,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt,
  output logic [2:0]            dbg_state
);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int CNT_W  = WORD_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    REF_AR = 3'd2,
    REF_R  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [31:2]      addr_q;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [WORD_W-1:0] req_off;

  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             fence_pend;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS][LINE_WORDS];

  logic ar_ok, ar_hs, hit, beat, beat_in_line, beat_err, line_ok, fence_now;

  assign req_tag = addr_q[31:OFF_W+IDX_W];
  assign req_idx = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign req_off = addr_q[OFF_W-1:2];

  assign ar_ok        = (state == IDLE) && !fence_pend && !reset;
  assign ar_hs        = ar_ok && bus.ifu_arvalid;
  assign hit          = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign beat         = (state == REF_R) && bus.mem_rvalid;
  // cnt saturates at LINE_WORDS, so its top bit marks beats past the end of the line
  assign beat_in_line = !cnt[WORD_W];
  assign beat_err     = (bus.mem_rresp != 2'b00);
  assign line_ok      = !err && !beat_err && (cnt == CNT_W'(LINE_WORDS - 1));
  assign fence_now    = (state == IDLE) && (fence_pend || (fence_i && !ar_hs));

  assign bus.mem_arlen   = 8'(LINE_WORDS - 1);
  assign bus.mem_arsize  = 3'b010;
  assign bus.mem_arburst = 2'b01;
  assign bus.ifu_rdata   = rdata_q;
  assign bus.ifu_rresp   = rresp_q;
  assign dbg_state       = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    bus.ifu_arready = 1'b0;
    bus.mem_arvalid = 1'b0;
    bus.mem_araddr  = '0;
    bus.mem_rready  = 1'b0;
    bus.ifu_rvalid  = 1'b0;
    bus.ifu_rlast   = 1'b0;
    case (state)
      IDLE: begin
        bus.ifu_arready = ar_ok;
        if (ar_hs) state_nx = LOOKUP;
      end
      LOOKUP: state_nx = hit ? RESP : REF_AR;
      REF_AR: begin
        bus.mem_arvalid = 1'b1;
        bus.mem_araddr  = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
        if (bus.mem_arready) state_nx = REF_R;
      end
      REF_R: begin
        bus.mem_rready = 1'b1;
        if (beat && bus.mem_rlast) state_nx = RESP;
      end
      RESP: begin
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rlast  = 1'b1;
        if (bus.ifu_rready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      fence_pend <= 1'b0;
      valid      <= '0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      if (ar_hs) addr_q <= bus.ifu_araddr[31:2];
      // a fence that cannot act this cycle waits for the next IDLE cycle
      if (fence_i && !((state == IDLE) && !ar_hs)) fence_pend <= 1'b1;
      else if (state == IDLE)                      fence_pend <= 1'b0;
      if (fence_now) valid <= '0;
      case (state)
        LOOKUP: begin
          if (hit) begin
            hit_cnt <= hit_cnt + 32'd1;
            rdata_q <= data_mem[req_idx][req_off];
            rresp_q <= 2'b00;
          end else begin
            miss_cnt         <= miss_cnt + 32'd1;
            valid[req_idx]   <= 1'b0;
            cnt              <= '0;
            err              <= 1'b0;
          end
        end
        REF_R: begin
          if (beat) begin
            if (beat_in_line) cnt <= cnt + CNT_W'(1);
            if (beat_err)     err <= 1'b1;
            if (beat_in_line && (cnt[WORD_W-1:0] == req_off)) rdata_q <= bus.mem_rdata;
            if (bus.mem_rlast) begin
              if (line_ok) begin
                valid[req_idx] <= 1'b1;
                rresp_q        <= 2'b00;
              end else begin
                rresp_q        <= 2'b10;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // line storage carries no reset; the valid bits alone say what is meaningful
  always_ff @(posedge clk) begin
    if (beat && beat_in_line) data_mem[req_idx][cnt[WORD_W-1:0]] <= bus.mem_rdata;
    if (beat && bus.mem_rlast && line_ok) tag_mem[req_idx] <= req_tag;
  end
endmodule
